// File: rtl/iter_shift_ctrl_if.sv
// Start/done handshake and operand bus between execute-stage control and
// the iterative shift/rotate sequencer.
interface iter_shift_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
);
    logic             start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] In;
    logic [CNT_W-1:0] Cnt;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Out;

    modport master (
        output start, Op, In, Cnt,
        input  ready, busy, done, Out
    );

    modport slave (
        input  start, Op, In, Cnt,
        output ready, busy, done, Out
    );
endinterface

// File: rtl/iter_shift_ctrl.sv
// Iterative 16-bit shift/rotate sequencer: one step per cycle until the count is spent.
// Define ITER_SHIFT_SKIP4_EN to take 4-bit steps while at least 4 remain.
module iter_shift_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    iter_shift_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] work, work_nxt;
    logic [CNT_W-1:0] rem, rem_nxt;
    logic [1:0]       op_q, op_nxt;
    logic [WIDTH-1:0] out_hold, out_hold_nxt;

    function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] w,
                                               input logic [1:0]       op);
        case (op)
            OP_ROL:  step1 = {w[WIDTH-2:0], w[WIDTH-1]};
            OP_SLL:  step1 = {w[WIDTH-2:0], 1'b0};
            OP_ROR:  step1 = {w[0], w[WIDTH-1:1]};
            default: step1 = {1'b0, w[WIDTH-1:1]};
        endcase
    endfunction

`ifdef ITER_SHIFT_SKIP4_EN
    localparam logic [CNT_W-1:0] FOUR = CNT_W'(4);

    // Equivalent to four consecutive step1() calls with the same op.
    function automatic logic [WIDTH-1:0] step4(input logic [WIDTH-1:0] w,
                                               input logic [1:0]       op);
        case (op)
            OP_ROL:  step4 = {w[WIDTH-5:0], w[WIDTH-1:WIDTH-4]};
            OP_SLL:  step4 = {w[WIDTH-5:0], 4'b0000};
            OP_ROR:  step4 = {w[3:0], w[WIDTH-1:4]};
            default: step4 = {4'b0000, w[WIDTH-1:4]};
        endcase
    endfunction
`endif

    always_comb begin
        state_nxt    = state;
        work_nxt     = work;
        rem_nxt      = rem;
        op_nxt       = op_q;
        out_hold_nxt = out_hold;

        case (state)
            ST_RUN: begin
`ifdef ITER_SHIFT_SKIP4_EN
                if (rem >= FOUR) begin
                    work_nxt = step4(work, op_q);
                    rem_nxt  = rem - FOUR;
                end else begin
                    work_nxt = step1(work, op_q);
                    rem_nxt  = rem - ONE;
                end
`else
                work_nxt = step1(work, op_q);
                rem_nxt  = rem - ONE;
`endif
                if (rem_nxt == '0) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // Latch the result so Out keeps it after the done cycle.
                out_hold_nxt = work;
                state_nxt    = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Accept from IDLE or DONE; overrides the DONE->IDLE default above.
        if (bus.start && (state != ST_RUN)) begin
            work_nxt  = bus.In;
            rem_nxt   = bus.Cnt;
            op_nxt    = bus.Op;
            state_nxt = (bus.Cnt == '0) ? ST_DONE : ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            work     <= '0;
            rem      <= '0;
            op_q     <= OP_ROL;
            out_hold <= '0;
        end else begin
            state    <= state_nxt;
            work     <= work_nxt;
            rem      <= rem_nxt;
            op_q     <= op_nxt;
            out_hold <= out_hold_nxt;
        end
    end

    assign bus.ready = (state != ST_RUN);
    assign bus.busy  = (state == ST_RUN);
    assign bus.done  = (state == ST_DONE);
    assign bus.Out   = (state == ST_DONE) ? work : out_hold;

endmodule

// File: tb/tb_iter_shift_ctrl.sv
// Self-checking bench for iter_shift_ctrl: directed cases from the test plan plus
// randomized operations against an arithmetic reference model.
module tb_iter_shift_ctrl;

    logic clk;
    logic rst;
    int   vectors;
    int   errors;

    iter_shift_ctrl_if #(.WIDTH(16), .CNT_W(4)) bus ();

    iter_shift_ctrl #(.WIDTH(16), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference: whole-operation result from the shift/rotate definitions.
    function automatic logic [15:0] model_out(input logic [1:0] op, input logic [15:0] x,
                                              input logic [3:0] c);
        int unsigned v;
        int unsigned n;
        int unsigned r;
        v = x;
        n = c;
        case (op)
            2'b00:   r = (v << n) | (v >> (16 - n));
            2'b01:   r = v << n;
            2'b10:   r = (v >> n) | (v << (16 - n));
            default: r = v >> n;
        endcase
        return r[15:0];
    endfunction

    function automatic int model_lat(input logic [3:0] c);
`ifdef ITER_SHIFT_SKIP4_EN
        return (int'(c) / 4) + (int'(c) % 4);
`else
        return int'(c);
`endif
    endfunction

    // Stimulus only: present an op, hold start across one rising edge.
    task automatic launch(input logic [1:0] op, input logic [15:0] x, input logic [3:0] c);
        bus.start = 1'b1;
        bus.Op    = op;
        bus.In    = x;
        bus.Cnt   = c;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Measurement only: edges until done, busy cycles seen, whether Out stayed put.
    task automatic wait_done(output int edges, output int busy_cyc, output bit held);
        logic [15:0] ref_out;
        ref_out  = bus.Out;
        edges    = 0;
        busy_cyc = 0;
        held     = 1'b1;
        while (bus.done !== 1'b1) begin
            if (edges >= 40) break;
            if (bus.busy === 1'b1) busy_cyc++;
            if (bus.Out !== ref_out) held = 1'b0;
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus.Out !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h want 0000", bus.Out); end
        vectors++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        vectors++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        vectors++;
        if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.ready); end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [1:0]  ops  [5] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b01};
        logic [15:0] ins  [5] = '{16'h8001, 16'h1234, 16'h8000, 16'h00FF, 16'hBEEF};
        logic [3:0]  cnts [5] = '{4'd1, 4'd4, 4'd15, 4'd8, 4'd0};
        logic [15:0] exps [5] = '{16'h0003, 16'h4123, 16'h0001, 16'hFF00, 16'hBEEF};
        int edges, busy_cyc;
        bit held;
        for (int i = 0; i < 5; i++) begin
            launch(ops[i], ins[i], cnts[i]);
            wait_done(edges, busy_cyc, held);
            vectors++;
            if (edges !== model_lat(cnts[i])) begin
                errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, edges, model_lat(cnts[i]));
            end
            vectors++;
            if (bus.Out !== exps[i]) begin
                errors++; $display("FAIL dir%0d_out: got %h want %h", i, bus.Out, exps[i]);
            end
            vectors++;
            if (busy_cyc !== model_lat(cnts[i])) begin
                errors++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, busy_cyc, model_lat(cnts[i]));
            end
            vectors++;
            if (!held) begin errors++; $display("FAIL dir%0d_out_hold_run: got changed want held", i); end
            @(posedge clk);
            #1;
            vectors++;
            if (bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.Out !== exps[i]) begin
                errors++;
                $display("FAIL dir%0d_after_done: got done=%b ready=%b out=%h want done=0 ready=1 out=%h",
                         i, bus.done, bus.ready, bus.Out, exps[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int edges, busy_cyc;
        bit held;
        launch(2'b01, 16'h0001, 4'd6);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.Op    = 2'b11;
        bus.In    = 16'hFFFF;
        bus.Cnt   = 4'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(edges, busy_cyc, held);
        vectors++;
        if (edges + 2 !== model_lat(4'd6)) begin
            errors++; $display("FAIL ignore_latency: got %0d want %0d", edges + 2, model_lat(4'd6));
        end
        vectors++;
        if (bus.Out !== 16'h0040) begin errors++; $display("FAIL ignore_out: got %h want 0040", bus.Out); end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL ignore_no_second: got done=%b want 0", bus.done); end
    endtask

    task automatic test_back_to_back();
        int edges, busy_cyc;
        bit held;
        launch(2'b10, 16'h00F0, 4'd3);
        wait_done(edges, busy_cyc, held);
        vectors++;
        if (bus.Out !== 16'h001E || bus.ready !== 1'b1) begin
            errors++; $display("FAIL b2b_first: got out=%h ready=%b want out=001e ready=1", bus.Out, bus.ready);
        end
        launch(2'b00, 16'hA5C3, 4'd5);
        wait_done(edges, busy_cyc, held);
        vectors++;
        if (edges !== model_lat(4'd5)) begin
            errors++; $display("FAIL b2b_latency: got %0d want %0d", edges, model_lat(4'd5));
        end
        vectors++;
        if (bus.Out !== model_out(2'b00, 16'hA5C3, 4'd5)) begin
            errors++; $display("FAIL b2b_out: got %h want %h", bus.Out, model_out(2'b00, 16'hA5C3, 4'd5));
        end
        vectors++;
        if (!held) begin errors++; $display("FAIL b2b_hold_prev: got changed want held at 001e"); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run();
        int seen;
        launch(2'b01, 16'h1357, 4'd10);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        vectors++;
        if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Out !== 16'h0000) begin
            errors++;
            $display("FAIL midrun_reset: got ready=%b busy=%b done=%b out=%h want 1 0 0 0000",
                     bus.ready, bus.busy, bus.done, bus.Out);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (seen !== 0) begin errors++; $display("FAIL midrun_quiet: got %0d active cycles want 0", seen); end
    endtask

    task automatic test_random();
        int edges, busy_cyc;
        bit held;
        logic [1:0]  op;
        logic [15:0] x;
        logic [3:0]  c;
        logic [15:0] want;
        for (int i = 0; i < 40; i++) begin
            op   = 2'($urandom_range(0, 3));
            x    = 16'($urandom);
            c    = 4'($urandom_range(0, 15));
            want = model_out(op, x, c);
            launch(op, x, c);
            wait_done(edges, busy_cyc, held);
            vectors++;
            if (edges !== model_lat(c)) begin
                errors++; $display("FAIL rand%0d_latency: op=%0d cnt=%0d got %0d want %0d", i, op, c, edges, model_lat(c));
            end
            vectors++;
            if (bus.Out !== want) begin
                errors++; $display("FAIL rand%0d_out: op=%0d in=%h cnt=%0d got %h want %h", i, op, x, c, bus.Out, want);
            end
            vectors++;
            if (!held) begin errors++; $display("FAIL rand%0d_hold: got changed want held", i); end
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    initial begin
        clk       = 1'b0;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.Op    = 2'b00;
        bus.In    = 16'h0000;
        bus.Cnt   = 4'd0;
        vectors   = 0;
        errors    = 0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/iter_shift_ctrl.md
Name: iter_shift_ctrl

Overview:
Multi-cycle sequencer for the 16-bit shift/rotate unit. Accepts one operation (rotate left, shift left logical, rotate right, shift right logical) with a 4-bit count. Applies a 1-bit shift/rotate step to an internal working register once per cycle until the count is exhausted. Sits beside the ALU as a low-area alternative to the combinational barrel shifter, with a start/done handshake toward the execute-stage control.

Parameters:
WIDTH, 16, datapath width; only 16 is supported.
CNT_W, 4, count width; a count of 0..15 is legal.

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  reset, synchronous, active-low (0 = reset)
start  input  1  request; sampled only when ready=1
Op  input  2  00=ROL, 01=SLL, 10=ROR, 11=SRL
In  input  16  operand, captured with start
Cnt  input  4  shift amount, captured with start
ready  output  1  1 when state is IDLE or DONE
busy  output  1  1 when state is RUN
done  output  1  1-cycle pulse; Out is valid while done=1
Out  output  16  result; holds until the next accepted start

Behaviour:
- Reset: rst=0 at a rising edge forces the following regardless of state, including mid-RUN:
  - state=IDLE, working register=0, remaining=0, Op register=00.
  - Outputs: Out=0x0000, done=0, busy=0, ready=1.
- States: IDLE, RUN, DONE.
- Accept: start=1 with ready=1 at edge E0 latches In, Op and Cnt. The working register is loaded with In and remaining is loaded with Cnt.
  - Cnt=0: next state is DONE.
  - Cnt>0: next state is RUN.
  - start while busy=1 is ignored and not queued.
- RUN, on each edge:
  - Working register takes a 1-bit step. ROL: {w[14:0],w[15]}. SLL: {w[14:0],0}. ROR: {w[0],w[15:1]}. SRL: {0,w[15:1]}.
  - remaining decrements by 1.
  - When remaining reaches 0 at that edge, next state is DONE.
- Latency: done=1 during the cycle following edge E_Cnt, i.e. Cnt cycles after acceptance. Cnt=0 gives done in the cycle right after E0.
- DONE:
  - done=1 for exactly one cycle.
  - Out equals the working register.
  - Next state is IDLE, or RUN/DONE if start=1 in this cycle. Back-to-back accept is legal because ready=1 in DONE.
- Out is driven from the working register only when done=1; it is held otherwise. Out does not change during RUN.
- Shift counts are modulo nothing: Cnt=15 performs 15 steps. No wrap to 0.
- Op is held constant for the entire operation; input changes after acceptance have no effect.

Optional Feature:
Macro ITER_SHIFT_SKIP4_EN.
- Defined: in RUN, when remaining >= 4, the working register takes a 4-bit step of the same Op and remaining decrements by 4. Otherwise it takes a 1-bit step and decrements by 1.
  - Cycle count = floor(Cnt/4) + (Cnt mod 4). Example: Cnt=15 gives done after edge E6.
  - Results are bit-identical to the non-macro build.
- Undefined: 1-bit steps only; latency equals Cnt cycles.

Test Plan:
- Reset, then start Op=ROL, In=0x8001, Cnt=1 -> done one cycle after accept, Out=0x0003, busy=1 for 1 cycle.
- Op=ROR, In=0x1234, Cnt=4 -> done after edge E4, Out=0x4123; with ITER_SHIFT_SKIP4_EN -> done after edge E1, same Out.
- Op=SRL, In=0x8000, Cnt=15 -> Out=0x0001 after 15 cycles (6 with macro); Op=SLL, In=0x00FF, Cnt=8 -> Out=0xFF00.
- Cnt=0, Op=SLL, In=0xBEEF -> done in the cycle right after accept, Out=0xBEEF, busy never asserted.
- start pulsed during RUN with a different In -> ignored, first result unchanged. start held in the DONE cycle -> second op accepted back-to-back, no idle cycle.
- rst=0 on the 3rd RUN cycle of a Cnt=10 op -> next cycle state=IDLE, Out=0x0000, done=0, ready=1; no done pulse afterwards.
